// File: rtl/ifu_lsu_rd_arbiter.sv
// Read arbiter that shares one memory read port between the IFU and the LSU.
// An order FIFO of {owner, araddr[2]} routes in-order memory responses back to the requester.
module ifu_lsu_rd_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  input  logic [63:0] ifu_araddr,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,
  output logic [1:0]  ifu_rresp,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_arvalid,
  output logic        lsu_arready,
  input  logic [63:0] lsu_araddr,
  output logic        lsu_rvalid,
  input  logic        lsu_rready,
  output logic [1:0]  lsu_rresp,
  output logic [63:0] lsu_rdata,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  output logic [63:0] mem_araddr,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  input  logic [1:0]  mem_rresp,
  input  logic [63:0] mem_rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    AR_IFU = 2'd1,
    AR_LSU = 2'd2
  } ar_state_t;

  ar_state_t         state_r;
  ar_state_t         next_state_s;
  logic [3:0]        wait_cnt_r;
  logic [CW-1:0]     cnt_r;
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [DEPTH-1:0]  fifo_owner_r;   // 1 = IFU owns the entry
  logic [DEPTH-1:0]  fifo_addr2_r;

  logic fifo_full_s;
  logic fifo_empty_s;
  logic ifu_prio_s;
  logic grant_lsu_s;
  logic grant_ifu_s;
  logic push_s;
  logic pop_s;
  logic head_owner_s;
  logic head_addr2_s;

  assign fifo_full_s  = (cnt_r == CW'(DEPTH));
  assign fifo_empty_s = (cnt_r == {CW{1'b0}});
  assign ifu_prio_s   = ifu_arvalid && (wait_cnt_r >= 4'(MAX_WAIT));
  assign grant_lsu_s  = (state_r == IDLE) && !fifo_full_s && lsu_arvalid && !ifu_prio_s;
  assign grant_ifu_s  = (state_r == IDLE) && !fifo_full_s && ifu_arvalid && !grant_lsu_s;
  assign push_s       = (state_r != IDLE) && mem_arready;
  assign pop_s        = mem_rvalid && mem_rready;
  assign head_owner_s = fifo_owner_r[rd_ptr_r];
  assign head_addr2_s = fifo_addr2_r[rd_ptr_r];

  assign mem_arvalid  = (state_r != IDLE);
  assign ifu_arready  = (state_r == AR_IFU) && mem_arready;
  assign lsu_arready  = (state_r == AR_LSU) && mem_arready;

  // AR channel next-state: grant from IDLE, hold until the memory accepts
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_lsu_s) begin
          next_state_s = AR_LSU;
        end else if (grant_ifu_s) begin
          next_state_s = AR_IFU;
        end else begin
          next_state_s = IDLE;
        end
      end
      AR_IFU, AR_LSU: begin
        if (mem_arready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Response routing to the owner of the oldest outstanding read
  always_comb begin
    ifu_rvalid = 1'b0;
    lsu_rvalid = 1'b0;
    mem_rready = 1'b0;
    ifu_rdata  = head_addr2_s ? mem_rdata[63:32] : mem_rdata[31:0];
    lsu_rdata  = mem_rdata;
    ifu_rresp  = mem_rresp;
    lsu_rresp  = mem_rresp;
    if (!fifo_empty_s) begin
      if (head_owner_s) begin
        ifu_rvalid = mem_rvalid;
        mem_rready = ifu_rready;
      end else begin
        lsu_rvalid = mem_rvalid;
        mem_rready = lsu_rready;
      end
    end else begin
      mem_rready = 1'b0;
    end
  end

  // AR state, latched address and IFU starvation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      mem_araddr <= 64'd0;
      wait_cnt_r <= 4'd0;
    end else begin
      state_r <= next_state_s;
      if (grant_lsu_s) begin
        mem_araddr <= lsu_araddr;
      end else if (grant_ifu_s) begin
        mem_araddr <= ifu_araddr;
      end
      if (grant_ifu_s) begin
        wait_cnt_r <= 4'd0;
      end else if (grant_lsu_s && ifu_arvalid && (wait_cnt_r != 4'd15)) begin
        wait_cnt_r <= wait_cnt_r + 4'd1;
      end
    end
  end

  // Order FIFO: push on AR handshake, pop on R handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      cnt_r        <= {CW{1'b0}};
      fifo_owner_r <= {DEPTH{1'b0}};
      fifo_addr2_r <= {DEPTH{1'b0}};
    end else begin
      if (push_s) begin
        fifo_owner_r[wr_ptr_r] <= (state_r == AR_IFU);
        fifo_addr2_r[wr_ptr_r] <= mem_araddr[2];
        wr_ptr_r               <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_lsu_rd_arbiter.sv
// Directed bench for ifu_lsu_rd_arbiter: arbitration, starvation guard, FIFO full,
// in-order response routing and mid-transaction reset.
module tb_ifu_lsu_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_arvalid, ifu_arready;
  logic [63:0] ifu_araddr;
  logic        ifu_rvalid, ifu_rready;
  logic [1:0]  ifu_rresp;
  logic [31:0] ifu_rdata;
  logic        lsu_arvalid, lsu_arready;
  logic [63:0] lsu_araddr;
  logic        lsu_rvalid, lsu_rready;
  logic [1:0]  lsu_rresp;
  logic [63:0] lsu_rdata;
  logic        mem_arvalid, mem_arready;
  logic [63:0] mem_araddr;
  logic        mem_rvalid, mem_rready;
  logic [1:0]  mem_rresp;
  logic [63:0] mem_rdata;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ifu_lsu_rd_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rresp(ifu_rresp), .ifu_rdata(ifu_rdata),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rresp(lsu_rresp), .lsu_rdata(lsu_rdata),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rresp(mem_rresp), .mem_rdata(mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
    ifu_araddr  = 64'd0; lsu_araddr = 64'd0;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rresp = 2'd0; mem_rdata = 64'd0;
    ifu_rready  = 1'b0; lsu_rready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One read request from IDLE; stall keeps mem_arready low after the master drops arvalid.
  task automatic ar_req(input logic is_ifu, input logic [63:0] addr, input int stall);
    @(negedge clk);
    mem_arready = (stall == 0);
    if (is_ifu) begin ifu_arvalid = 1'b1; ifu_araddr = addr; end
    else        begin lsu_arvalid = 1'b1; lsu_araddr = addr; end
    @(negedge clk); #1;
    check_eq("ar_valid", 64'(mem_arvalid), 64'd1);
    check_eq("ar_addr", mem_araddr, addr);
    ifu_arvalid = 1'b0;
    lsu_arvalid = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk); #1;
      check_eq("ar_held_after_drop", 64'(mem_arvalid), 64'd1);
      check_eq("ar_addr_stable", mem_araddr, addr);
    end
    mem_arready = 1'b1; #1;
    check_eq("ar_ifu_ready", 64'(ifu_arready), 64'(is_ifu));
    check_eq("ar_lsu_ready", 64'(lsu_arready), 64'(!is_ifu));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a28 [5];
    logic        exp_ifu;

    // Reset with busy-looking inputs: every valid/ready output must be 0
    rst_n = 1'b0;
    clear_inputs();
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1; mem_arready = 1'b1;
    mem_rvalid = 1'b1; ifu_rready = 1'b1; lsu_rready = 1'b1;
    #1;
    repeat (2) begin
      @(negedge clk); #1;
      check_eq("rst_mem_arvalid", 64'(mem_arvalid), 64'd0);
      check_eq("rst_ifu_arready", 64'(ifu_arready), 64'd0);
      check_eq("rst_lsu_arready", 64'(lsu_arready), 64'd0);
      check_eq("rst_mem_rready", 64'(mem_rready), 64'd0);
      check_eq("rst_ifu_rvalid", 64'(ifu_rvalid), 64'd0);
      check_eq("rst_lsu_rvalid", 64'(lsu_rvalid), 64'd0);
      check_eq("rst_mem_araddr", mem_araddr, 64'd0);
    end

    // Both request: LSU first, then 8 LSU grants force one IFU grant
    do_reset();
    @(negedge clk);
    ifu_arvalid = 1'b1; ifu_araddr = 64'h6000;
    lsu_arvalid = 1'b1; lsu_araddr = 64'h5000;
    mem_rvalid = 1'b1; ifu_rready = 1'b1; lsu_rready = 1'b1;
    #1;
    check_eq("idle_no_arvalid", 64'(mem_arvalid), 64'd0);
    @(negedge clk); #1;
    check_eq("both_arvalid", 64'(mem_arvalid), 64'd1);
    check_eq("both_addr_lsu", mem_araddr, 64'h5000);
    check_eq("both_lsu_ready_low", 64'(lsu_arready), 64'd0);
    mem_arready = 1'b1; #1;
    check_eq("both_lsu_ready_follows", 64'(lsu_arready), 64'd1);
    check_eq("both_ifu_ready_zero", 64'(ifu_arready), 64'd0);
    for (int g = 2; g <= 10; g++) begin
      exp_ifu = (g == 9);
      @(negedge clk); #1;
      check_eq("bubble_idle", 64'(mem_arvalid), 64'd0);
      @(negedge clk); #1;
      check_eq("rr_arvalid", 64'(mem_arvalid), 64'd1);
      check_eq("rr_addr", mem_araddr, exp_ifu ? 64'h6000 : 64'h5000);
      check_eq("rr_ifu_ready", 64'(ifu_arready), 64'(exp_ifu));
      check_eq("rr_lsu_ready", 64'(lsu_arready), 64'(!exp_ifu));
    end

    // FIFO full blocks grants; beats select the 32-bit half by araddr[2]
    do_reset();
    a28[0] = 64'h1000; a28[1] = 64'h1004; a28[2] = 64'h1008; a28[3] = 64'h100C; a28[4] = 64'h2000;
    for (int i = 0; i < 4; i++) ar_req(1'b1, a28[i], 0);
    @(negedge clk);
    ifu_arvalid = 1'b1; ifu_araddr = a28[4];
    repeat (3) begin
      @(negedge clk); #1;
      check_eq("full_no_arvalid", 64'(mem_arvalid), 64'd0);
      check_eq("full_ifu_arready", 64'(ifu_arready), 64'd0);
    end
    check_eq("full_rready_held", 64'(mem_rready), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 64'h11112222_33334444; mem_rresp = 2'b00; ifu_rready = 1'b1; #1;
    check_eq("beat1_ifu_rvalid", 64'(ifu_rvalid), 64'd1);
    check_eq("beat1_mem_rready", 64'(mem_rready), 64'd1);
    check_eq("beat1_ifu_rdata", 64'(ifu_rdata), 64'h33334444);
    check_eq("beat1_lsu_rvalid", 64'(lsu_rvalid), 64'd0);
    @(negedge clk); #1;
    check_eq("beat2_ifu_rdata", 64'(ifu_rdata), 64'h11112222);
    check_eq("beat2_still_no_ar", 64'(mem_arvalid), 64'd0);
    mem_rresp = 2'b10; #1;
    check_eq("beat2_ifu_rresp", 64'(ifu_rresp), 64'h2);
    @(negedge clk); #1;
    check_eq("after_pop_grant", 64'(mem_arvalid), 64'd1);
    check_eq("after_pop_addr", mem_araddr, 64'h2000);
    check_eq("beat3_ifu_rdata", 64'(ifu_rdata), 64'h33334444);

    // Interleaved IFU/LSU/IFU with delayed responses and an early arvalid drop
    do_reset();
    ifu_rready = 1'b1; lsu_rready = 1'b1;
    ar_req(1'b1, 64'h2004, 2);
    ar_req(1'b0, 64'h3000, 0);
    ar_req(1'b1, 64'h2008, 0);
    @(negedge clk); #1;
    check_eq("wait_ifu_rvalid", 64'(ifu_rvalid), 64'd0);
    check_eq("wait_lsu_rvalid", 64'(lsu_rvalid), 64'd0);
    check_eq("head_ifu_rready", 64'(mem_rready), 64'd1);
    lsu_rready = 1'b0; #1;
    check_eq("head_ifu_ignores_lsu_rready", 64'(mem_rready), 64'd1);
    lsu_rready = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'hAAAABBBB_CCCCDDDD; mem_rresp = 2'b00; #1;
    check_eq("il1_ifu_rvalid", 64'(ifu_rvalid), 64'd1);
    check_eq("il1_lsu_rvalid", 64'(lsu_rvalid), 64'd0);
    check_eq("il1_ifu_rdata", 64'(ifu_rdata), 64'hAAAABBBB);
    @(negedge clk);
    mem_rdata = 64'h01234567_89ABCDEF; mem_rresp = 2'b11; #1;
    check_eq("il2_lsu_rvalid", 64'(lsu_rvalid), 64'd1);
    check_eq("il2_ifu_rvalid", 64'(ifu_rvalid), 64'd0);
    check_eq("il2_lsu_rdata", lsu_rdata, 64'h01234567_89ABCDEF);
    check_eq("il2_lsu_rresp", 64'(lsu_rresp), 64'h3);
    @(negedge clk);
    mem_rdata = 64'h55556666_77778888; mem_rresp = 2'b00; #1;
    check_eq("il3_ifu_rvalid", 64'(ifu_rvalid), 64'd1);
    check_eq("il3_lsu_rvalid", 64'(lsu_rvalid), 64'd0);
    check_eq("il3_ifu_rdata", 64'(ifu_rdata), 64'h77778888);
    @(negedge clk); #1;
    check_eq("empty_ifu_rvalid", 64'(ifu_rvalid), 64'd0);
    check_eq("empty_lsu_rvalid", 64'(lsu_rvalid), 64'd0);
    check_eq("empty_mem_rready", 64'(mem_rready), 64'd0);

    // Reset with three outstanding reads and an IFU request waiting on mem_arready
    do_reset();
    ifu_rready = 1'b1;
    ar_req(1'b1, 64'h4000, 0);
    ar_req(1'b1, 64'h4004, 0);
    ar_req(1'b0, 64'h4100, 0);
    @(negedge clk);
    ifu_arvalid = 1'b1; ifu_araddr = 64'h4200; mem_arready = 1'b0;
    @(negedge clk); #1;
    check_eq("pre_rst_arvalid", 64'(mem_arvalid), 64'd1);
    check_eq("pre_rst_rready", 64'(mem_rready), 64'd1);
    rst_n = 1'b0; #1;
    check_eq("mid_rst_arvalid", 64'(mem_arvalid), 64'd0);
    check_eq("mid_rst_rready", 64'(mem_rready), 64'd0);
    check_eq("mid_rst_ifu_arready", 64'(ifu_arready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; ifu_arvalid = 1'b0; mem_arready = 1'b1; #1;
    check_eq("post_rst_rready", 64'(mem_rready), 64'd0);
    ar_req(1'b0, 64'h4300, 0);
    lsu_rready = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 64'hDEADBEEF_CAFEF00D; #1;
    check_eq("post_rst_lsu_rvalid", 64'(lsu_rvalid), 64'd1);
    check_eq("post_rst_ifu_rvalid", 64'(ifu_rvalid), 64'd0);
    check_eq("post_rst_lsu_rdata", lsu_rdata, 64'hDEADBEEF_CAFEF00D);
    @(negedge clk); #1;
    check_eq("post_rst_drained_lsu", 64'(lsu_rvalid), 64'd0);
    check_eq("post_rst_drained_ifu", 64'(ifu_rvalid), 64'd0);
    mem_rvalid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ifu_lsu_rd_arbiter.md
IFU_LSU_RD_ARBITER -- requirements
Module: ifu_lsu_rd_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, max outstanding slave reads (power of two, 2..8).
REQ-002 SHALL have parameter MAX_WAIT, default 8, consecutive IFU losses before forced IFU grant (1..15).
REQ-003 SHALL have clk input 1: the single clock; all state on rising edge.
REQ-004 SHALL have rst_n input 1: asynchronous, active-low reset.
REQ-005 SHALL have ifu_arvalid input 1 / ifu_arready output 1 / ifu_araddr input 64: IFU read-address channel.
REQ-006 SHALL have ifu_rvalid output 1 / ifu_rready input 1 / ifu_rresp output 2 / ifu_rdata output 32: IFU read-data channel.
REQ-007 SHALL have lsu_arvalid input 1 / lsu_arready output 1 / lsu_araddr input 64: LSU read-address channel.
REQ-008 SHALL have lsu_rvalid output 1 / lsu_rready input 1 / lsu_rresp output 2 / lsu_rdata output 64: LSU read-data channel.
REQ-009 SHALL have mem_arvalid output 1 / mem_arready input 1 / mem_araddr output 64: shared memory read-address channel.
REQ-010 SHALL have mem_rvalid input 1 / mem_rready output 1 / mem_rresp input 2 / mem_rdata input 64: shared memory read-data channel (in-order responses).

Function
REQ-011 SHALL implement AR states IDLE, AR_IFU, AR_LSU; mem_arvalid = (state != IDLE).
REQ-012 In IDLE with cnt < DEPTH: LSU request wins unless ifu_arvalid and wait_cnt >= MAX_WAIT; winner's address latched into mem_araddr; next state AR_<winner>.
REQ-013 In IDLE with cnt == DEPTH: no grant, state stays IDLE, wait_cnt unchanged.
REQ-014 In AR_x: x_arready = mem_arready (other master's arready = 0); on mem_arvalid&mem_arready return to IDLE; mem_araddr stable throughout.
REQ-015 Latency: master request in IDLE -> mem_arvalid next cycle; one IDLE bubble between consecutive grants.
REQ-016 If a granted master drops arvalid before handshake, latched request SHALL still complete and its response SHALL be routed to that master.
REQ-017 wait_cnt (4 bit) SHALL increment, saturating at 15, on each IDLE grant to LSU while ifu_arvalid=1; clear on IFU grant.
REQ-018 SHALL keep an order FIFO of DEPTH entries {owner, araddr[2]}; push on mem AR handshake, pop on mem R handshake; cnt = occupancy (0..DEPTH).
REQ-019 Simultaneous push and pop SHALL leave cnt unchanged; pointers wrap modulo DEPTH.
REQ-020 FIFO empty: mem_rready = 0, ifu_rvalid = lsu_rvalid = 0, mem_rvalid ignored.
REQ-021 FIFO non-empty, head owner IFU: ifu_rvalid = mem_rvalid, mem_rready = ifu_rready, ifu_rdata = head.addr2 ? mem_rdata[63:32] : mem_rdata[31:0], ifu_rresp = mem_rresp.
REQ-022 Head owner LSU: lsu_rvalid = mem_rvalid, mem_rready = lsu_rready, lsu_rdata = mem_rdata, lsu_rresp = mem_rresp.
REQ-023 Non-head master's rvalid SHALL be 0; rdata/rresp pass-through is combinational (zero added latency).

Reset
REQ-024 rst_n low SHALL asynchronously force state IDLE, cnt 0, pointers 0, wait_cnt 0, mem_araddr 0.
REQ-025 During/after reset all valid/ready outputs SHALL be 0; reset mid-transaction discards all outstanding entries.

Verification
REQ-026 Both arvalid=1 in IDLE, cnt 0, wait_cnt 0 -> next cycle mem_arvalid=1, mem_araddr=lsu_araddr, lsu_arready follows mem_arready, ifu_arready=0.
REQ-027 Both request continuously, MAX_WAIT=8, mem_arready=1 -> 8 LSU grants then 1 IFU grant, wait_cnt back to 0.
REQ-028 IFU reads 0x1000, 0x1004, mem_rready held, DEPTH=4 -> at cnt=4 no mem_arvalid; first R beat mem_rdata=0x11112222_33334444 -> ifu_rdata 0x33334444, second -> 0x11112222.
REQ-029 Interleaved IFU, LSU, IFU grants with delayed R -> responses routed IFU, LSU, IFU in order; lsu_rvalid=0 while IFU head.
REQ-030 rst_n pulsed low with cnt=3 and state AR_IFU -> immediately mem_arvalid=0, mem_rready=0; after release cnt=0, new request granted normally.
